// File: rtl/pt2262_encoder_gen.sv
// rtl/pt2262_encoder_gen.sv - PT2262-style tri-state remote-control frame encoder
module pt2262_encoder_gen #(
    parameter int N_ADDR  = 8,
    parameter int N_DATA  = 4,
    parameter int DIVIDER = 250,
    parameter int REPEATS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2*N_ADDR-1:0]   A,
    input  logic [N_DATA-1:0]     D,
    output logic                  busy,
    output logic                  done,
    output logic                  cod_o,
    output logic                  sync
);

    localparam int NPOS  = N_ADDR + N_DATA;
    localparam int POS_W = $clog2(NPOS);
    localparam int DIV_W = $clog2(DIVIDER);

    localparam logic [POS_W-1:0] LAST_POS   = POS_W'(NPOS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIVIDER - 1);
    localparam logic [7:0]       LAST_FRAME = 8'(REPEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_BIT,
        S_SEND_SYNC
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [POS_W-1:0]    pos_q;
    logic [2:0]          bit_slot_q;
    logic [4:0]          sync_slot_q;
    logic [7:0]          frame_q;
    logic [2*N_ADDR-1:0] a_q;
    logic [N_DATA-1:0]   d_q;
    logic                busy_q;
    logic                done_q;
    logic                cod_q;
    logic                sync_q;

    logic                tick;
    logic [1:0]          cur_code;
    logic [2:0]          bit_slot_d;
    logic                wide;
    logic                next_hi;

    assign tick = (state_q != S_IDLE) && (div_q == DIV_LAST);

    // Slot timer: free-runs only while a transmission is active, wraps on tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (state_q == S_IDLE || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Tri-state code of the position being sent: A0..A(N-1), then D(M-1)..D0
    always_comb begin
        cur_code = 2'b00;
        for (int i = 0; i < N_ADDR; i++) begin
            if (pos_q == POS_W'(i)) cur_code = a_q[2*i +: 2];
        end
        for (int j = 0; j < N_DATA; j++) begin
            if (pos_q == POS_W'(NPOS - 1 - j)) cur_code = {1'b0, d_q[j]};
        end
    end

    // Level of the next slot inside a bit: each half is 1H3L (narrow) or 3H1L (wide);
    // bit 1 is wide in both halves, bit F only in the second half
    always_comb begin
        bit_slot_d = bit_slot_q + 3'd1;
        wide       = cur_code[1] ? bit_slot_d[2] : cur_code[0];
        next_hi    = wide ? (bit_slot_d[1:0] != 2'b11) : (bit_slot_d[1:0] == 2'b00);
    end

    // Frame sequencer with registered serial outputs; levels change only on tick or acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            bit_slot_q  <= '0;
            sync_slot_q <= '0;
            frame_q     <= '0;
            a_q         <= '0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cod_q       <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q         <= A;
                        d_q         <= D;
                        pos_q       <= '0;
                        bit_slot_q  <= '0;
                        sync_slot_q <= '0;
                        frame_q     <= '0;
                        busy_q      <= 1'b1;
                        cod_q       <= 1'b1;
                        sync_q      <= 1'b0;
                        state_q     <= S_SEND_BIT;
                    end
                end
                S_SEND_BIT: begin
                    if (tick) begin
                        if (bit_slot_q == 3'd7) begin
                            // Every bit and the sync bit start with a high slot
                            bit_slot_q <= '0;
                            cod_q      <= 1'b1;
                            if (pos_q == LAST_POS) begin
                                state_q     <= S_SEND_SYNC;
                                sync_slot_q <= '0;
                                sync_q      <= 1'b1;
                            end else begin
                                pos_q <= pos_q + POS_W'(1);
                            end
                        end else begin
                            bit_slot_q <= bit_slot_d;
                            cod_q      <= next_hi;
                        end
                    end
                end
                S_SEND_SYNC: begin
                    if (tick) begin
                        sync_q <= 1'b0;
                        if (sync_slot_q == 5'd31) begin
                            if (frame_q == LAST_FRAME) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                cod_q   <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                frame_q    <= frame_q + 8'd1;
                                pos_q      <= '0;
                                bit_slot_q <= '0;
                                cod_q      <= 1'b1;
                                state_q    <= S_SEND_BIT;
                            end
                        end else begin
                            sync_slot_q <= sync_slot_q + 5'd1;
                            cod_q       <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign cod_o = cod_q;
    assign sync  = sync_q;

endmodule

// File: doc/pt2262_encoder_gen.md
PT2262_ENCODER_GEN -- requirements
Module: pt2262_encoder_gen

Interface
REQ-001 SHALL have parameter N_ADDR, default 8: number of tri-state address positions (legal 1..16).
REQ-002 SHALL have parameter N_DATA, default 4: number of binary data positions (legal 1..8).
REQ-003 SHALL have parameter DIVIDER, default 250: clk cycles per alpha slot (legal >= 2).
REQ-004 SHALL have parameter REPEATS, default 4: frames sent per accepted request (legal 1..255).
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: transmit request.
REQ-008 SHALL have port A, input, 2*N_ADDR bits: A[2i+1:2i] codes address position i (00=bit 0, 01=bit 1, 1x=bit F).
REQ-009 SHALL have port D, input, N_DATA bits: data value.
REQ-010 SHALL have port busy, output, 1 bit: transmission in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port cod_o, output, 1 bit: encoded serial waveform.
REQ-013 SHALL have port sync, output, 1 bit: copy of cod_o during sync bits only, else 0.

Function
REQ-014 SHALL use an internal slot counter that counts 0..DIVIDER-1, enabled only when busy, cleared in IDLE, and produces a one-cycle tick at DIVIDER-1; no derived clocks.
REQ-015 SHALL accept start only in IDLE; on acceptance, A and D are latched, busy=1 and cod_o=1 from the same edge, and slot 0 of bit A0 begins.
REQ-016 SHALL ignore start while busy; the latched A and D SHALL NOT change mid-transmission.
REQ-017 SHALL build each address/data bit from 8 slots as H/L patterns: bit 0 = 1H 3L 1H 3L; bit 1 = 3H 1L 3H 1L; bit F = 1H 3L 3H 1L.
REQ-018 SHALL build the sync bit from 32 slots: 1H 31L.
REQ-019 SHALL send each frame in the order A0..A(N_ADDR-1), then D(N_DATA-1)..D0, then SYNC: (N_ADDR+N_DATA)*8+32 slots.
REQ-020 SHALL send exactly REPEATS back-to-back frames with no gap, using the same latched values.
REQ-021 SHALL register cod_o, changing only on tick edges (or on the acceptance edge), so each slot lasts exactly DIVIDER clk cycles.
REQ-022 SHALL implement states IDLE -> SEND_BIT (per-position index, 3-bit slot index) -> SEND_SYNC (5-bit slot index) -> SEND_BIT for the next frame while the frame count is below REPEATS, else -> IDLE.
REQ-023 SHALL, on the tick ending the last sync slot of the last frame, pulse done=1 for one cycle and set busy=0 and cod_o=0 on that same edge.
REQ-024 SHALL accept a start that is high in the cycle after done, with no dead cycle required.
REQ-025 SHALL treat code 10 and code 11 on an A position identically (bit F).

Reset
REQ-026 SHALL, when reset is low, asynchronously force IDLE, busy=0, done=0, cod_o=0, sync=0, and clear all counters, including mid-frame.
REQ-027 SHALL ignore start while reset is low, and SHALL accept a start no earlier than the first clk edge after reset deasserts.

Verification
REQ-028 SHALL pass this scenario: N_ADDR=8, N_DATA=4, DIVIDER=4, REPEATS=1; A all 00, D=0; start -> cod_o shows twelve "1H3L1H3L" bits then 1H31L, busy high for exactly 512 cycles, done pulses once.
REQ-029 SHALL pass this scenario: A=16'hFF55 (A0..A3 = 1, A4..A7 = F), D=4'b1010 -> bit sequence 1,1,1,1,F,F,F,F,1,0,1,0,SYNC, and sync is high only for the 4 cycles of the sync H slot.
REQ-030 SHALL pass this scenario: REPEATS=3 -> three identical contiguous frames, busy=1536 cycles, single done pulse.
REQ-031 SHALL pass this scenario: start pulsed again mid-frame with a different A -> no effect on the waveform, frame count, or done timing.
REQ-032 SHALL pass this scenario: reset low during bit D2 -> outputs 0 immediately (before the next clk edge); a new start after release produces a fresh full frame from A0.
REQ-033 SHALL pass this scenario: start held high continuously -> a new transmission begins on the edge after each done, with cod_o=1 on that edge.
